// File: rtl/decode38_pulse_pkg.sv
// Shared types and defaults for the decode38_pulse pulse generator:
// FSM state encoding, field widths and the one-hot decode helper.
package decode38_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_PULSE_LEN  = 4;
    localparam int DEF_GAP_LEN    = 1;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int CODE_W  = 3;
    localparam int DOUT_W  = 8;
    localparam int COUNT_W = 5;
    localparam int TIMER_W = 4;

    function automatic logic [DOUT_W-1:0] onehot3(input logic [CODE_W-1:0] code);
        return DOUT_W'(1) << code;
    endfunction

endpackage

// File: rtl/decode38_pulse_if.sv
// Code-in / pulse-out bundle: master produces codes and observes the decode,
// slave is the decoder itself.
interface decode38_pulse_if;

    logic       en;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic [7:0] d_out;
    logic       busy;
    logic [4:0] count;

    modport master (
        output en, in_valid, in_code,
        input  in_ready, d_out, busy, count
    );

    modport slave (
        input  en, in_valid, in_code,
        output in_ready, d_out, busy, count
    );

endinterface

// File: rtl/decode38_pulse_code_fifo.sv
// Code queue for decode38_pulse: power-of-two depth circular buffer with
// occupancy count, combinational head read and no push-to-pop bypass.
module code_fifo
    import decode38_pulse_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_push,
    input  logic [CODE_W-1:0]  i_data,
    input  logic               i_pop,
    output logic [CODE_W-1:0]  o_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [COUNT_W-1:0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [CODE_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full  = (r_count == COUNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full queue refuses the push even when the same edge pops an entry.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    // NOTE: the storage array has no reset; pointers and count alone decide
    // which entries are valid, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values no matter how the statements are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/decode38_pulse.sv
// Queued 3-to-8 decoder: each accepted code is shown one-hot on d_out for
// PULSE_LEN enabled cycles, followed by GAP_LEN all-zero enabled cycles.
module decode38_pulse
    import decode38_pulse_pkg::*;
#(
    parameter int PULSE_LEN  = DEF_PULSE_LEN,
    parameter int GAP_LEN    = DEF_GAP_LEN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic             clk,
    input logic             rst_n,
    decode38_pulse_if.slave bus
);

    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_LEN - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   =
        (GAP_LEN == 0) ? '0 : TIMER_W'(GAP_LEN - 1);

    state_t              r_state;
    logic [TIMER_W-1:0]  r_timer;
    logic [DOUT_W-1:0]   r_dout;

    logic                w_full;
    logic                w_empty;
    logic [CODE_W-1:0]   w_head;
    logic [COUNT_W-1:0]  w_count;
    logic                w_push;
    logic                w_pop;
    logic                w_launch_pt;

    assign w_push = bus.in_valid;

    code_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_code_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (bus.in_code),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // The last DRIVE cycle (with no gap) and the last GAP cycle act as IDLE,
    // so exactly GAP_LEN zero cycles separate back-to-back pulses.
    // NOTE: every always_comb output gets a default first so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_launch_pt = 1'b0;
        case (r_state)
            ST_IDLE:  w_launch_pt = 1'b1;
            ST_DRIVE: w_launch_pt = (r_timer == '0) && (GAP_LEN == 0);
            ST_GAP:   w_launch_pt = (r_timer == '0);
            default:  w_launch_pt = 1'b0;
        endcase
    end

    assign w_pop = bus.en && w_launch_pt && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_dout  <= '0;
        end else if (bus.en) begin
            if (w_pop) begin
                r_state <= ST_DRIVE;
                r_timer <= PULSE_LOAD;
                r_dout  <= onehot3(w_head);
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_dout <= '0;
                    end
                    ST_DRIVE: begin
                        if (r_timer == '0) begin
                            r_dout <= '0;
                            if (GAP_LEN == 0) begin
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_GAP;
                                r_timer <= GAP_LOAD;
                            end
                        end else begin
                            r_timer <= r_timer - TIMER_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (r_timer == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_timer <= r_timer - TIMER_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_timer <= '0;
                        r_dout  <= '0;
                    end
                endcase
            end
        end
    end

    // Blanked while stalled; r_dout keeps the held code for when en returns.
    assign bus.d_out    = bus.en ? r_dout : '0;
    assign bus.in_ready = !w_full;
    assign bus.busy     = (r_state != ST_IDLE) || !w_empty;
    assign bus.count    = w_count;

endmodule

// File: tb/tb_decode38_pulse.sv
// Bench for decode38_pulse: two instances (GAP_LEN 1 and 0) share stimulus and
// are compared every cycle against a counter-and-list model, plus literal pins.
module tb_decode38_pulse;
    import decode38_pulse_pkg::*;

    localparam int PULSE  = 4;
    localparam int DEPTH  = 4;
    localparam int N_INST = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [2:0] in_code;

    int n_checks = 0;
    int n_errors = 0;

    decode38_pulse_if bus0 ();
    decode38_pulse_if bus1 ();

    assign bus0.en       = en;
    assign bus0.in_valid = in_valid;
    assign bus0.in_code  = in_code;
    assign bus1.en       = en;
    assign bus1.in_valid = in_valid;
    assign bus1.in_code  = in_code;

    decode38_pulse #(.PULSE_LEN(PULSE), .GAP_LEN(1), .FIFO_DEPTH(DEPTH)) u_dut_gap1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    decode38_pulse #(.PULSE_LEN(PULSE), .GAP_LEN(0), .FIFO_DEPTH(DEPTH)) u_dut_gap0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    logic [7:0] dout_a  [N_INST];
    logic       ready_a [N_INST];
    logic       busy_a  [N_INST];
    logic [4:0] count_a [N_INST];

    assign dout_a[0]  = bus0.d_out;
    assign dout_a[1]  = bus1.d_out;
    assign ready_a[0] = bus0.in_ready;
    assign ready_a[1] = bus1.in_ready;
    assign busy_a[0]  = bus0.busy;
    assign busy_a[1]  = bus1.busy;
    assign count_a[0] = bus0.count;
    assign count_a[1] = bus1.count;

    always #5 clk = ~clk;

    // Model: a list of pending codes plus "drive cycles left" / "gap cycles left".
    int m_buf   [N_INST][DEPTH];
    int m_len   [N_INST];
    int m_cur   [N_INST];
    int m_drive [N_INST];
    int m_gap   [N_INST];

    function automatic int gap_len_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic logic [7:0] exp_dout(input int i);
        return (en && m_drive[i] > 0) ? 8'(1 << m_cur[i]) : 8'h00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_INST; i++) begin
            m_len[i]   = 0;
            m_cur[i]   = 0;
            m_drive[i] = 0;
            m_gap[i]   = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < N_INST; i++) begin
            int pre_len;
            bit accept;
            pre_len = m_len[i];
            accept  = in_valid && (pre_len < DEPTH);
            if (en) begin
                if (m_drive[i] > 0) begin
                    m_drive[i]--;
                    if (m_drive[i] == 0) m_gap[i] = gap_len_of(i);
                end else if (m_gap[i] > 0) begin
                    m_gap[i]--;
                end
                if (m_drive[i] == 0 && m_gap[i] == 0 && pre_len > 0) begin
                    m_cur[i] = m_buf[i][0];
                    for (int k = 0; k < DEPTH - 1; k++) m_buf[i][k] = m_buf[i][k + 1];
                    m_len[i]--;
                    m_drive[i] = PULSE;
                end
            end
            if (accept) begin
                m_buf[i][m_len[i]] = int'(in_code);
                m_len[i]++;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("model d_out[%0d]", i),    32'(dout_a[i]),  32'(exp_dout(i)));
            check($sformatf("model in_ready[%0d]", i), 32'(ready_a[i]), 32'(m_len[i] != DEPTH));
            check($sformatf("model busy[%0d]", i),     32'(busy_a[i]),
                  32'(m_drive[i] > 0 || m_gap[i] > 0 || m_len[i] > 0));
            check($sformatf("model count[%0d]", i),    32'(count_a[i]), 32'(m_len[i]));
            check($sformatf("onehot[%0d]", i),         32'($countones(dout_a[i]) <= 1), 32'(1));
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic pin_dout(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        check({tag, " d_out0"}, 32'(dout_a[0]), 32'(e0));
        check({tag, " d_out1"}, 32'(dout_a[1]), 32'(e1));
    endtask

    task automatic pin_state(input string tag, input int cnt, input bit rdy);
        for (int i = 0; i < N_INST; i++) begin
            check($sformatf("%s count%0d", tag, i), 32'(count_a[i]), 32'(cnt));
            check($sformatf("%s ready%0d", tag, i), 32'(ready_a[i]), 32'(rdy));
        end
    endtask

    task automatic pin_busy(input string tag, input bit b0, input bit b1);
        check({tag, " busy0"}, 32'(busy_a[0]), 32'(b0));
        check({tag, " busy1"}, 32'(busy_a[1]), 32'(b1));
    endtask

    // Asserts rst_n between clock edges and pins the outputs before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        pin_dout({tag, " async"}, 8'h00, 8'h00);
        pin_state({tag, " async"}, 0, 1'b1);
        pin_busy({tag, " async"}, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int         n_hi [N_INST];
        logic [7:0] e0;
        logic [7:0] e1;

        rst_n    = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
        in_code  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        pin_dout("reset", 8'h00, 8'h00);
        pin_state("reset", 0, 1'b1);
        pin_busy("reset", 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // Single code 5: one cycle of latency, four cycles of 8'h20.
        in_valid = 1'b1;
        in_code  = 3'd5;
        step();
        in_valid = 1'b0;
        pin_dout("single accept", 8'h00, 8'h00);
        pin_state("single accept", 1, 1'b1);
        for (int j = 0; j < PULSE; j++) begin
            step();
            pin_dout("single high", 8'h20, 8'h20);
        end
        step();
        pin_dout("single low", 8'h00, 8'h00);
        pin_busy("single gap", 1'b1, 1'b0);
        step();
        pin_busy("single done", 1'b0, 1'b0);

        // Burst to full while stalled; code 4 must be refused.
        en       = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_code = 3'(c);
            step();
            if (c >= 3) pin_state("burst full", DEPTH, 1'b0);
        end
        // Enable with in_valid still high on a full queue: the pop edge refuses code 7.
        en      = 1'b1;
        in_code = 3'd7;
        step();
        in_valid = 1'b0;
        pin_state("full pop", DEPTH - 1, 1'b1);
        for (int t = 0; t < 20; t++) begin
            if (t > 0) step();
            e0 = (t % 5 < 4) ? 8'(1 << (t / 5)) : 8'h00;
            e1 = (t < 16) ? 8'(1 << (t / 4)) : 8'h00;
            pin_dout($sformatf("burst seq t%0d", t), e0, e1);
        end
        step();
        pin_busy("burst drained", 1'b0, 1'b0);

        // Codes 6 then 7: back-to-back on the gapless instance.
        in_valid = 1'b1;
        in_code  = 3'd6;
        step();
        in_code  = 3'd7;
        step();
        in_valid = 1'b0;
        for (int t = 0; t < 10; t++) begin
            if (t > 0) step();
            e0 = (t < 4) ? 8'h40 : (t == 4) ? 8'h00 : (t < 9) ? 8'h80 : 8'h00;
            e1 = (t < 4) ? 8'h40 : (t < 8) ? 8'h80 : 8'h00;
            pin_dout($sformatf("b2b seq t%0d", t), e0, e1);
        end
        step();

        // Enable stall during the second cycle of a pulse of code 2.
        in_valid = 1'b1;
        in_code  = 3'd2;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < N_INST; i++) n_hi[i] = 0;
        repeat (2) begin
            step();
            for (int i = 0; i < N_INST; i++) if (dout_a[i] == 8'h04) n_hi[i]++;
        end
        en = 1'b0;
        #1;
        pin_dout("stall enter", 8'h00, 8'h00);
        repeat (3) begin
            step();
            pin_dout("stall", 8'h00, 8'h00);
        end
        en = 1'b1;
        repeat (6) begin
            step();
            for (int i = 0; i < N_INST; i++) if (dout_a[i] == 8'h04) n_hi[i]++;
        end
        check("stall pulse cycles0", 32'(n_hi[0]), 32'(PULSE));
        check("stall pulse cycles1", 32'(n_hi[1]), 32'(PULSE));

        // Reset mid-pulse with codes still queued.
        in_valid = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            in_code = 3'(c);
            step();
        end
        in_valid = 1'b0;
        pin_dout("pre-reset", 8'h02, 8'h02);
        async_reset("midpulse");
        step();
        pin_dout("post-reset", 8'h00, 8'h00);
        pin_state("post-reset", 0, 1'b1);

        // Randomized traffic with stalls and an occasional asynchronous reset.
        for (int n = 0; n < 1500; n++) begin
            en       = ($urandom_range(0, 7) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_code  = 3'($urandom_range(0, 7));
            step();
            if ($urandom_range(0, 399) == 0) async_reset("random");
        end
        en       = 1'b1;
        in_valid = 1'b0;
        repeat (40) step();
        pin_busy("final drain", 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode38_pulse.md
DECODE38_PULSE -- requirements
Module: decode38_pulse

Interface
REQ-001 Parameter PULSE_LEN, default 4, SHALL set the cycles each decoded one-hot output is driven (legal 1..15).
REQ-002 Parameter GAP_LEN, default 1, SHALL set the all-zero cycles between consecutive pulses (legal 0..15).
REQ-003 Parameter FIFO_DEPTH, default 4, SHALL set the input code queue depth (power of two, 2..16).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  run enable; low SHALL freeze the pulse engine.
REQ-007 in_valid  input  1  in_code is presented.
REQ-008 in_code  input  3  binary code 0..7 to decode.
REQ-009 in_ready  output  1  queue can accept; SHALL equal (queue count != FIFO_DEPTH).
REQ-010 d_out  output  8  registered one-hot decode, bit in_code high, or 8'h00.
REQ-011 busy  output  1  high when state != IDLE or queue non-empty.
REQ-012 count  output  5  current queue occupancy, 0..FIFO_DEPTH.

Function
REQ-013 A code SHALL be accepted at a rising edge where in_valid && in_ready; the accepted code SHALL be written to the queue tail.
REQ-014 FSM states SHALL be IDLE, DRIVE, GAP.
REQ-015 IDLE: if en && queue non-empty, pop head, load d_out = 8'b1 << code, load timer = PULSE_LEN-1, go DRIVE; else d_out = 8'h00.
REQ-016 DRIVE: timer decrements each enabled cycle; at timer==0, d_out SHALL go 8'h00 and FSM go GAP with timer = GAP_LEN-1, or if GAP_LEN==0 behave as IDLE in that same edge (back-to-back pulse when queue non-empty).
REQ-017 GAP: timer decrements each enabled cycle; at timer==0 go IDLE.
REQ-018 Minimum latency SHALL be one cycle: code accepted at edge k into empty queue while IDLE shall appear on d_out after edge k+1.
REQ-019 Each code SHALL drive d_out for exactly PULSE_LEN cycles while en stays high; d_out SHALL never have more than one bit set.
REQ-020 No bypass: a push into an empty queue SHALL NOT be popped in the same edge.
REQ-021 Queue full: in_ready low; in_valid ignored even if a pop occurs in the same edge.
REQ-022 Simultaneous push and pop on a non-full, non-empty queue SHALL leave count unchanged and preserve order.
REQ-023 Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 en low: timer, FSM and pops SHALL hold; d_out SHALL read 8'h00 while en is low and resume the held one-hot value when en returns high; pushes SHALL continue.
REQ-025 Codes SHALL be emitted in acceptance order with none lost or duplicated.

Reset
REQ-026 On rst_n low, immediately and independent of clk: FSM=IDLE, timer=0, queue pointers and count=0, d_out=8'h00, in_ready=1, busy=0.
REQ-027 Reset mid-pulse SHALL abort the pulse and discard all queued codes; operation resumes from the first rising edge after rst_n deasserts.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration (2-bit) and the default PULSE_LEN/GAP_LEN/FIFO_DEPTH constants.
REQ-029 The queue SHALL be one sub-module, code_fifo (push/pop, full/empty, count); the FSM, timer and decode register SHALL reside in decode38_pulse.

Verification
REQ-030 Reset: rst_n low asynchronously mid-pulse -> d_out=8'h00, count=0, in_ready=1 without a clock edge.
REQ-031 Single code: defaults, push 3'd5 at edge k -> d_out=8'h20 after edges k+1..k+4, 8'h00 for 1 cycle, busy low after the gap ends.
REQ-032 Burst to full: push 0,1,2,3,4 back-to-back while en low -> in_ready low after 4th push, code 4 not accepted; with en high, outputs 8'h01,8'h02,8'h04,8'h08 in order, each 4 cycles, 1-cycle gaps.
REQ-033 GAP_LEN=0: push 6 then 7 -> d_out 8'h40 for 4 cycles immediately followed by 8'h80, no zero cycle.
REQ-034 Enable stall: drop en for 3 cycles during 2nd cycle of a pulse of code 2 -> d_out 8'h00 during stall, total 4 cycles of 8'h04 observed.
REQ-035 Full with pop: queue full, in_valid high on the pop edge -> code not accepted, count drops to FIFO_DEPTH-1.
